// File: rtl/bank_group_cmd_fsm.sv
// Bank-group command front end: per-bank ACT/RD/WR/PRE tracking with tRCD/tRP, burst column generation.
// Optional AUTO_PRECHARGE_EN: RD/WR with cmd_addr[10]=1 precharges the bank after its final beat.

module bank_group_cmd_fsm_bank #(
    parameter int ADDRWIDTH = 17,
    parameter int COLWIDTH  = 10,
    parameter int BL        = 8,
    parameter int TRCD      = 3,
    parameter int TRP       = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 hit,
    input  logic [2:0]           cmd,
    input  logic [ADDRWIDTH-1:0] addr,
    output logic                 rej,
    output logic                 rd_o_wr,
    output logic [ADDRWIDTH-1:0] row,
    output logic [COLWIDTH-1:0]  column,
    output logic                 beat_valid,
    output logic                 bank_open
);
    localparam int BLW  = $clog2(BL);
    localparam int TMAX = (TRCD > TRP) ? TRCD : TRP;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [COLWIDTH-1:0] WRAP = COLWIDTH'(BL - 1);
    localparam logic [BLW-1:0]      LAST = BLW'(BL - 1);
    localparam logic [2:0] C_ACT = 3'd1, C_RD = 3'd2, C_WR = 3'd3, C_PRE = 3'd4;

    typedef enum logic [2:0] {IDLE, ACTIVATING, ACTIVE, READ, WRITE, PRECHARGING} state_t;

    state_t         state;
    logic [TW-1:0]  timer;
    logic [BLW-1:0] cnt;
    logic           ap;
    logic           ap_req;
    logic           acc;

`ifdef AUTO_PRECHARGE_EN
    assign ap_req = addr[10];
`else
    assign ap_req = 1'b0;
`endif

    always_comb begin
        rej = 1'b0;
        if (hit) begin
            case (cmd)
                C_ACT:      rej = (state != IDLE);
                C_RD, C_WR: rej = (state != ACTIVE);
                C_PRE:      rej = (state != IDLE) && (state != ACTIVE);
                default:    rej = 1'b0;
            endcase
        end
    end

    assign acc       = hit && !rej;
    assign bank_open = (state == ACTIVE) || (state == READ) || (state == WRITE);

    // Timers are loaded with t-1 so the bank is usable exactly t cycles after the command.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            timer      <= '0;
            cnt        <= '0;
            ap         <= 1'b0;
            row        <= '0;
            column     <= '0;
            rd_o_wr    <= 1'b0;
            beat_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (acc && cmd == C_ACT) begin
                        row   <= addr;
                        timer <= TW'(TRCD - 1);
                        state <= (TRCD == 1) ? ACTIVE : ACTIVATING;
                    end
                end
                ACTIVATING: begin
                    if (timer <= TW'(1)) begin
                        timer <= '0;
                        state <= ACTIVE;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                ACTIVE: begin
                    if (acc && (cmd == C_RD || cmd == C_WR)) begin
                        column     <= addr[COLWIDTH-1:0];
                        rd_o_wr    <= (cmd == C_WR);
                        state      <= (cmd == C_WR) ? WRITE : READ;
                        beat_valid <= 1'b1;
                        cnt        <= '0;
                        ap         <= ap_req;
                    end else if (acc && cmd == C_PRE) begin
                        timer <= TW'(TRP - 1);
                        state <= (TRP == 1) ? IDLE : PRECHARGING;
                    end
                end
                READ, WRITE: begin
                    if (cnt == LAST) begin
                        beat_valid <= 1'b0;
                        if (ap) begin
                            timer <= TW'(TRP - 1);
                            state <= (TRP == 1) ? IDLE : PRECHARGING;
                        end else begin
                            state <= ACTIVE;
                        end
                    end else begin
                        cnt    <= cnt + 1'b1;
                        // wrap inside the BL-aligned block
                        column <= (column & ~WRAP) | ((column + 1'b1) & WRAP);
                    end
                end
                PRECHARGING: begin
                    if (timer <= TW'(1)) begin
                        timer <= '0;
                        state <= IDLE;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

module bank_group_cmd_fsm #(
    parameter int BAWIDTH   = 2,
    parameter int ADDRWIDTH = 17,
    parameter int COLWIDTH  = 10,
    parameter int BL        = 8,
    parameter int TRCD      = 3,
    parameter int TRP       = 3,
    localparam int BANKSPERGROUP = 2 ** BAWIDTH
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         cmd_valid,
    input  logic [2:0]                                   cmd,
    input  logic [BAWIDTH-1:0]                           cmd_ba,
    input  logic [ADDRWIDTH-1:0]                         cmd_addr,
    output logic                                         cmd_err,
    output logic [BANKSPERGROUP-1:0]                     rd_o_wr,
    output logic [BANKSPERGROUP-1:0][ADDRWIDTH-1:0]      row,
    output logic [BANKSPERGROUP-1:0][COLWIDTH-1:0]       column,
    output logic [BANKSPERGROUP-1:0]                     beat_valid,
    output logic [BANKSPERGROUP-1:0]                     bank_open
);
    logic [BANKSPERGROUP-1:0] rej;
    logic                     legal;

    assign legal = cmd_valid && (cmd >= 3'd1) && (cmd <= 3'd4);

    for (genvar b = 0; b < BANKSPERGROUP; b++) begin : g_bank
        bank_group_cmd_fsm_bank #(
            .ADDRWIDTH(ADDRWIDTH),
            .COLWIDTH (COLWIDTH),
            .BL       (BL),
            .TRCD     (TRCD),
            .TRP      (TRP)
        ) u_bank (
            .clk       (clk),
            .rst       (rst),
            .hit       (legal && (cmd_ba == BAWIDTH'(b))),
            .cmd       (cmd),
            .addr      (cmd_addr),
            .rej       (rej[b]),
            .rd_o_wr   (rd_o_wr[b]),
            .row       (row[b]),
            .column    (column[b]),
            .beat_valid(beat_valid[b]),
            .bank_open (bank_open[b])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) cmd_err <= 1'b0;
        else     cmd_err <= (cmd_valid && cmd > 3'd4) || (|rej);
    end
endmodule

// File: tb/tb_bank_group_cmd_fsm.sv
// Directed bench for bank_group_cmd_fsm: timing windows, burst columns, overlap, reset abort, auto-precharge.
module tb_bank_group_cmd_fsm;
    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic [2:0]       cmd;
    logic [1:0]       cmd_ba;
    logic [16:0]      cmd_addr;
    logic             cmd_err;
    logic [3:0]       rd_o_wr;
    logic [3:0][16:0] row;
    logic [3:0][9:0]  column;
    logic [3:0]       beat_valid;
    logic [3:0]       bank_open;

    int n_chk = 0;
    int n_fail = 0;

    localparam logic [2:0] NOP = 3'd0, ACT = 3'd1, RD = 3'd2, WR = 3'd3, PRE = 3'd4;

    bank_group_cmd_fsm dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ba(cmd_ba),
        .cmd_addr(cmd_addr), .cmd_err(cmd_err), .rd_o_wr(rd_o_wr), .row(row),
        .column(column), .beat_valid(beat_valid), .bank_open(bank_open)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Present one cycle of inputs; returns 1 time unit after the edge that consumed them.
    task automatic step(input logic v, input logic [2:0] c, input logic [1:0] ba, input logic [16:0] a);
        cmd_valid = v; cmd = c; cmd_ba = ba; cmd_addr = a;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(0, NOP, 0, 0);
        step(0, NOP, 0, 0);
        n_chk++; if ({cmd_err, rd_o_wr, beat_valid, bank_open} !== 13'd0) begin
            n_fail++; $display("FAIL reset_flags: got %h want 0", {cmd_err, rd_o_wr, beat_valid, bank_open});
        end
        n_chk++; if (row !== '0 || column !== '0) begin
            n_fail++; $display("FAIL reset_rowcol: got row %h col %h want 0", row, column);
        end
        rst = 1'b0;
    endtask

    task automatic test_act_read();
        step(1, ACT, 1, 17'h1ABCD);
        n_chk++; if (row[1] !== 17'h1ABCD) begin n_fail++; $display("FAIL act_row: got %h want 1abcd", row[1]); end
        n_chk++; if (bank_open[1] !== 1'b0 || cmd_err !== 1'b0) begin
            n_fail++; $display("FAIL act_activating: got open %b err %b want 0 0", bank_open[1], cmd_err);
        end
        step(0, NOP, 0, 0);
        step(1, RD, 1, 17'h005);      // ACT+2: too early
        n_chk++; if (cmd_err !== 1'b1 || beat_valid[1] !== 1'b0) begin
            n_fail++; $display("FAIL early_rd: got err %b bv %b want 1 0", cmd_err, beat_valid[1]);
        end
        step(1, RD, 1, 17'h005);      // ACT+3: legal
        n_chk++; if (cmd_err !== 1'b0) begin n_fail++; $display("FAIL rd_err_pulse: got %b want 0", cmd_err); end
        n_chk++; if (rd_o_wr[1] !== 1'b0 || bank_open[1] !== 1'b1) begin
            n_fail++; $display("FAIL rd_flags: got rw %b open %b want 0 1", rd_o_wr[1], bank_open[1]);
        end
        for (int k = 0; k < 8; k++) begin
            if (k > 0) step(0, NOP, 0, 0);
            n_chk++; if (beat_valid[1] !== 1'b1 || column[1] !== 10'((5 + k) % 8)) begin
                n_fail++; $display("FAIL rd_beat%0d: got bv %b col %h want 1 %h", k, beat_valid[1], column[1], (5 + k) % 8);
            end
        end
        step(0, NOP, 0, 0);
        n_chk++; if (beat_valid[1] !== 1'b0 || column[1] !== 10'h004 || bank_open[1] !== 1'b1) begin
            n_fail++; $display("FAIL rd_end: got bv %b col %h open %b want 0 004 1", beat_valid[1], column[1], bank_open[1]);
        end
    endtask

    task automatic test_overlap();
        step(1, ACT, 0, 17'h00011);
        step(1, ACT, 2, 17'h00022);
        step(0, NOP, 0, 0);
        step(0, NOP, 0, 0);
        step(1, RD, 2, 17'h010);      // bank2 beat 0
        step(0, NOP, 0, 0);           // bank2 beat 1
        step(1, WR, 0, 17'h3F8);      // bank2 beat 2, bank0 beat 0
        for (int k = 0; k < 8; k++) begin
            if (k > 0) step(0, NOP, 0, 0);
            n_chk++; if (beat_valid[0] !== 1'b1 || column[0] !== 10'(10'h3F8 + k) || rd_o_wr[0] !== 1'b1) begin
                n_fail++; $display("FAIL wr0_beat%0d: got bv %b col %h rw %b want 1 %h 1", k, beat_valid[0], column[0], rd_o_wr[0], 10'h3F8 + k);
            end
            if (k + 2 < 8) begin
                n_chk++; if (beat_valid[2] !== 1'b1 || column[2] !== 10'(10'h010 + k + 2) || rd_o_wr[2] !== 1'b0) begin
                    n_fail++; $display("FAIL rd2_beat%0d: got bv %b col %h rw %b want 1 %h 0", k + 2, beat_valid[2], column[2], rd_o_wr[2], 10'h010 + k + 2);
                end
            end else begin
                n_chk++; if (beat_valid[2] !== 1'b0 || column[2] !== 10'h017) begin
                    n_fail++; $display("FAIL rd2_done%0d: got bv %b col %h want 0 017", k, beat_valid[2], column[2]);
                end
            end
        end
        step(0, NOP, 0, 0);
        n_chk++; if (beat_valid !== 4'b0000 || row[2] !== 17'h00022) begin
            n_fail++; $display("FAIL overlap_end: got bv %b row2 %h want 0000 00022", beat_valid, row[2]);
        end
    endtask

    task automatic test_precharge();
        step(1, RD, 1, 17'h000);      // beat 0
        step(0, NOP, 0, 0);
        step(1, PRE, 1, 0);           // mid-burst
        n_chk++; if (cmd_err !== 1'b1 || beat_valid[1] !== 1'b1) begin
            n_fail++; $display("FAIL pre_in_burst: got err %b bv %b want 1 1", cmd_err, beat_valid[1]);
        end
        for (int k = 0; k < 6; k++) step(0, NOP, 0, 0);
        n_chk++; if (bank_open[1] !== 1'b1 || beat_valid[1] !== 1'b0) begin
            n_fail++; $display("FAIL post_burst: got open %b bv %b want 1 0", bank_open[1], beat_valid[1]);
        end
        step(1, PRE, 1, 0);
        n_chk++; if (bank_open[1] !== 1'b0 || cmd_err !== 1'b0) begin
            n_fail++; $display("FAIL pre_close: got open %b err %b want 0 0", bank_open[1], cmd_err);
        end
        step(0, NOP, 0, 0);
        step(1, ACT, 1, 17'h0FFFF);   // PRE+2: too early
        n_chk++; if (cmd_err !== 1'b1 || row[1] !== 17'h1ABCD) begin
            n_fail++; $display("FAIL early_act: got err %b row %h want 1 1abcd", cmd_err, row[1]);
        end
        step(1, ACT, 1, 17'h00123);   // PRE+3: legal
        n_chk++; if (cmd_err !== 1'b0 || row[1] !== 17'h00123) begin
            n_fail++; $display("FAIL act_after_pre: got err %b row %h want 0 00123", cmd_err, row[1]);
        end
    endtask

    task automatic test_illegal();
        step(1, 3'd5, 3, 0);
        n_chk++; if (cmd_err !== 1'b1) begin n_fail++; $display("FAIL code5: got %b want 1", cmd_err); end
        step(1, PRE, 3, 0);           // idle bank: legal no-op
        n_chk++; if (cmd_err !== 1'b0 || bank_open[3] !== 1'b0) begin
            n_fail++; $display("FAIL idle_pre: got err %b open %b want 0 0", cmd_err, bank_open[3]);
        end
        step(1, ACT, 0, 0);           // bank0 already open
        n_chk++; if (cmd_err !== 1'b1 || row[0] !== 17'h00011) begin
            n_fail++; $display("FAIL act_open: got err %b row %h want 1 00011", cmd_err, row[0]);
        end
    endtask

    task automatic test_reset_midburst();
        // bank1 was activated at the end of test_precharge, 3 steps ago
        step(1, WR, 1, 17'h020);      // beat 0
        n_chk++; if (cmd_err !== 1'b0 || beat_valid[1] !== 1'b1) begin
            n_fail++; $display("FAIL wr_start: got err %b bv %b want 0 1", cmd_err, beat_valid[1]);
        end
        step(0, NOP, 0, 0);
        step(0, NOP, 0, 0);
        step(0, NOP, 0, 0);           // beat 3 visible
        n_chk++; if (column[1] !== 10'h023) begin n_fail++; $display("FAIL wr_beat3: got %h want 023", column[1]); end
        rst = 1'b1;
        step(0, NOP, 0, 0);
        rst = 1'b0;
        n_chk++; if ({cmd_err, rd_o_wr, beat_valid, bank_open} !== 13'd0 || row !== '0 || column !== '0) begin
            n_fail++; $display("FAIL rst_abort: got flags %h row %h col %h want 0", {cmd_err, rd_o_wr, beat_valid, bank_open}, row, column);
        end
        step(0, NOP, 0, 0);
        n_chk++; if (beat_valid !== 4'b0000) begin n_fail++; $display("FAIL rst_nobeat: got %b want 0000", beat_valid); end
        step(1, ACT, 0, 17'h00077);   // bank0 idle again
        n_chk++; if (cmd_err !== 1'b0) begin n_fail++; $display("FAIL rst_idle0: got %b want 0", cmd_err); end
        step(1, RD, 2, 0);            // bank2 idle, not active
        n_chk++; if (cmd_err !== 1'b1) begin n_fail++; $display("FAIL rst_idle2: got %b want 1", cmd_err); end
    endtask

    task automatic test_auto_precharge();
        step(1, ACT, 3, 17'h00055);
        step(0, NOP, 0, 0);
        step(0, NOP, 0, 0);
        step(1, RD, 3, 17'h00400);
        for (int k = 0; k < 8; k++) begin
            if (k > 0) step(0, NOP, 0, 0);
            n_chk++; if (beat_valid[3] !== 1'b1 || column[3] !== 10'(k)) begin
                n_fail++; $display("FAIL ap_beat%0d: got bv %b col %h want 1 %h", k, beat_valid[3], column[3], k);
            end
        end
        step(0, NOP, 0, 0);           // cycle after last beat (L)
`ifdef AUTO_PRECHARGE_EN
        n_chk++; if (bank_open[3] !== 1'b0 || beat_valid[3] !== 1'b0) begin
            n_fail++; $display("FAIL ap_close: got open %b bv %b want 0 0", bank_open[3], beat_valid[3]);
        end
        step(0, NOP, 0, 0);
        step(1, ACT, 3, 17'h00066);   // L+2
        n_chk++; if (cmd_err !== 1'b1) begin n_fail++; $display("FAIL ap_early_act: got %b want 1", cmd_err); end
        step(1, ACT, 3, 17'h00066);   // L+3 = last beat + TRP
        n_chk++; if (cmd_err !== 1'b0 || row[3] !== 17'h00066) begin
            n_fail++; $display("FAIL ap_act: got err %b row %h want 0 00066", cmd_err, row[3]);
        end
`else
        n_chk++; if (bank_open[3] !== 1'b1 || beat_valid[3] !== 1'b0) begin
            n_fail++; $display("FAIL noap_open: got open %b bv %b want 1 0", bank_open[3], beat_valid[3]);
        end
        step(1, RD, 3, 17'h003);
        n_chk++; if (cmd_err !== 1'b0 || column[3] !== 10'h003) begin
            n_fail++; $display("FAIL noap_rd: got err %b col %h want 0 003", cmd_err, column[3]);
        end
`endif
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd = NOP; cmd_ba = '0; cmd_addr = '0;
        test_reset();
        test_act_read();
        test_overlap();
        test_precharge();
        test_illegal();
        test_reset_midburst();
        test_auto_precharge();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/bank_group_cmd_fsm.md
Name: bank_group_cmd_fsm

Overview:
- Per-bank-group command front end. Accepts decoded DDR commands (ACT/RD/WR/PRE) addressed to one bank of the group.
- Tracks each bank's open row and state, and enforces tRCD/tRP.
- Generates the per-bank row, column, rd_o_wr and beat-valid vectors consumed directly by the bank-group storage array.
- Sits between the rank-level command decoder and the bank-group array; one instance per bank group.

Parameters:
- BAWIDTH, 2, bank address bits; BANKSPERGROUP = 2**BAWIDTH (localparam).
- ADDRWIDTH, 17, row address bits.
- COLWIDTH, 10, column address bits.
- BL, 8, burst length in beats; power of two, 2..2**COLWIDTH; BLW = log2(BL) (localparam).
- TRCD, 3, cycles from ACT accept until RD/WR is legal on that bank; >=1.
- TRP, 3, cycles from PRE accept until ACT is legal on that bank; >=1.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command present this cycle.
- cmd  input  3  0=NOP, 1=ACT, 2=RD, 3=WR, 4=PRE; 5-7 illegal.
- cmd_ba  input  BAWIDTH  target bank.
- cmd_addr  input  ADDRWIDTH  row for ACT; low COLWIDTH bits = start column for RD/WR.
- cmd_err  output  1  one-cycle pulse when a valid command is rejected.
- rd_o_wr  output  [BANKSPERGROUP][1]  per bank: 1=write beat, 0=read.
- row  output  [BANKSPERGROUP][ADDRWIDTH]  latched open row per bank.
- column  output  [BANKSPERGROUP][COLWIDTH]  current beat column per bank.
- beat_valid  output  [BANKSPERGROUP][1]  a burst beat is active on that bank this cycle.
- bank_open  output  [BANKSPERGROUP][1]  bank is in ACTIVE, READ or WRITE.

Behaviour:
- Reset, applied synchronously:
  - all banks go to IDLE;
  - rd_o_wr, row, column, beat_valid, bank_open and cmd_err are all 0;
  - timers and beat counters clear.
  - rst asserted mid-burst aborts the burst at the next edge; no further beats.
- Per-bank states: IDLE, ACTIVATING, ACTIVE, READ, WRITE, PRECHARGING.
- Command acceptance: a command is taken only when cmd_valid=1 and cmd!=NOP; it affects only bank cmd_ba. One command per cycle. Other banks proceed independently, including overlapping bursts.
- IDLE + ACT:
  - row[ba] <= cmd_addr;
  - load timer with TRCD;
  - go to ACTIVATING.
- ACTIVATING: timer decrements each cycle; at 0 go to ACTIVE. RD/WR is legal exactly TRCD cycles after the ACT cycle.
- ACTIVE + RD or WR:
  - latch start column;
  - rd_o_wr[ba] <= (cmd==WR);
  - go to READ or WRITE.
  - First beat appears the cycle after acceptance: column=start, beat_valid=1.
- READ/WRITE:
  - BL consecutive beats. Beat k column = {start[COLWIDTH-1:BLW], (start[BLW-1:0]+k) mod BL}, i.e. wrap inside the BL-aligned block.
  - After beat BL-1, return to ACTIVE.
  - beat_valid is 0 in every other state.
  - column holds its last value; rd_o_wr holds until the next RD/WR.
- ACTIVE + PRE: load timer with TRP; go to PRECHARGING. bank_open drops the next cycle.
- PRECHARGING: at timer 0 go to IDLE. row is retained but not meaningful.
- IDLE + PRE: legal no-op, no error.
- Rejected commands (cmd_err=1 the following cycle, state unchanged):
  - ACT to a non-IDLE bank;
  - RD/WR to a bank not in ACTIVE, including mid-burst and during ACTIVATING;
  - PRE during READ/WRITE, ACTIVATING or PRECHARGING;
  - cmd codes 5-7.
- Latency: command to first beat = 1 cycle; command to state-output change = 1 cycle.

Optional Feature:
- Macro: AUTO_PRECHARGE_EN.
- With the macro defined:
  - a RD/WR with cmd_addr[10]=1 (requires ADDRWIDTH>10) schedules auto-precharge;
  - after the final beat the bank goes straight to PRECHARGING with timer TRP instead of ACTIVE;
  - bank_open drops the cycle after the last beat.
- Without the macro: cmd_addr[10] is ignored for RD/WR and bursts always return to ACTIVE.

Test Plan:
- Reset then ACT ba=1 row=0x1ABCD, RD ba=1 col=0x005 at ACT+3 -> row[1]=0x1ABCD; beats col 5,6,7,0,1,2,3,4 (low 3 bits, upper bits 0) on 8 consecutive cycles; beat_valid[1]=1 for exactly 8 cycles; rd_o_wr[1]=0.
- RD ba=1 issued at ACT+2 (early) -> cmd_err pulses once, no beats; RD at ACT+3 accepted.
- WR ba=0 col=0x3F8 while bank 2 mid-read -> both banks beat simultaneously; rd_o_wr[0]=1, columns 0x3F8..0x3FF; bank 2 unaffected.
- PRE during active burst -> cmd_err=1; PRE after burst -> bank_open falls next cycle; ACT at PRE+2 -> cmd_err; ACT at PRE+3 -> accepted.
- rst asserted at beat 3 of a write -> next cycle beat_valid=0, all outputs 0, all banks IDLE.
- AUTO_PRECHARGE_EN build: RD with cmd_addr[10]=1 -> 8 beats, then PRECHARGING; ACT accepted exactly TRP cycles after the last beat; without the macro the same stimulus leaves bank_open=1.
